// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot decoder with an optional dwell-timed scan sequencer.
// Scan support (SCAN/DONE states, dwell counter) is built only when SCAN_DECODER_SCAN_EN is defined.
module scan_decoder #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DWELL  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   mode,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      addr,
    output logic [2**ADDR_W-1:0]   out,
    output logic [ADDR_W-1:0]      cur_addr,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned OUT_W = 2 ** ADDR_W;

    logic [OUT_W-1:0]  out_q, out_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;

    function automatic logic [OUT_W-1:0] onehot(input logic [ADDR_W-1:0] idx);
        logic [OUT_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q      <= '0;
            cur_addr_q <= '0;
        end else begin
            out_q      <= out_d;
            cur_addr_q <= cur_addr_d;
        end
    end

    assign out      = out_q;
    assign cur_addr = cur_addr_q;

`ifdef SCAN_DECODER_SCAN_EN

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    // dwell_q counts enabled edges already spent on the current index
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t            state_q, state_d;
    logic [7:0]        dwell_q, dwell_d;
    logic [ADDR_W-1:0] next_addr;

    assign next_addr = cur_addr_q + ADDR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        out_d      = out_q;
        cur_addr_d = cur_addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (!enable) begin
                    out_d = '0;
                end else if (mode && start) begin
                    state_d    = S_SCAN;
                    cur_addr_d = '0;
                    dwell_d    = '0;
                    out_d      = onehot('0);
                end else begin
                    out_d      = onehot(addr);
                    cur_addr_d = addr;
                end
            end
            S_SCAN: begin
                if (!enable) begin
                    out_d = '0;
                end else if (dwell_q != DWELL_LAST) begin
                    dwell_d = dwell_q + 8'd1;
                    out_d   = onehot(cur_addr_q);
                end else if (cur_addr_q == '1) begin
                    state_d = S_DONE;
                    out_d   = '0;
                end else begin
                    cur_addr_d = next_addr;
                    dwell_d    = '0;
                    out_d      = onehot(next_addr);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                out_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                out_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == S_SCAN);
    assign done = (state_q == S_DONE);

`else

    localparam int unsigned unused_dwell = DWELL;
    logic unused_scan_inputs;
    assign unused_scan_inputs = mode ^ start;

    always_comb begin
        out_d      = enable ? onehot(addr) : '0;
        cur_addr_d = enable ? addr : cur_addr_q;
    end

    assign busy = 1'b0;
    assign done = 1'b0;

`endif

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: directed scenarios plus randomized traffic against
// a step-counting reference model; honours SCAN_DECODER_SCAN_EN like the design.
module tb_scan_decoder;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DWELL  = 2;
    localparam int unsigned N      = 4;
`ifdef SCAN_DECODER_SCAN_EN
    localparam bit SCAN_EN = 1'b1;
`else
    localparam bit SCAN_EN = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic       mode   = 1'b0;
    logic       start  = 1'b0;
    logic [1:0] addr   = '0;
    logic [3:0] out;
    logic [1:0] cur_addr;
    logic       busy, done;

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] exp_direct [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] exp_scan   [8] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010,
                                   4'b0100, 4'b0100, 4'b1000, 4'b1000};

    scan_decoder #(.ADDR_W(ADDR_W), .DWELL(DWELL)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .mode     (mode),
        .start    (start),
        .addr     (addr),
        .out      (out),
        .cur_addr (cur_addr),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a scan is N*DWELL enabled display slots; slot s shows index s/DWELL.
    bit          m_scan, m_done;
    int unsigned m_steps;
    logic [3:0]  m_out;
    logic [1:0]  m_cur;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_scan <= 1'b0; m_done <= 1'b0; m_steps <= 0; m_out <= '0; m_cur <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_out  <= '0;
        end else if (m_scan) begin
            if (!enable) begin
                m_out <= '0;
            end else if (m_steps + 1 == N * DWELL) begin
                m_scan <= 1'b0;
                m_done <= 1'b1;
                m_out  <= '0;
            end else begin
                m_steps <= m_steps + 1;
                m_cur   <= 2'((m_steps + 1) / DWELL);
                m_out   <= 4'(1 << ((m_steps + 1) / DWELL));
            end
        end else if (!enable) begin
            m_out <= '0;
        end else if (SCAN_EN && mode && start) begin
            m_scan  <= 1'b1;
            m_steps <= 0;
            m_cur   <= '0;
            m_out   <= 4'b0001;
        end else begin
            m_out <= 4'(1 << addr);
            m_cur <= addr;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("model_out", out, m_out);
            check("model_cur_addr", cur_addr, m_cur);
            check("model_busy", busy, m_scan);
            check("model_done", done, m_done);
            check("onehot0_out", $onehot0(out), 1);
            check("busy_and_done", busy & done, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic wait_out(input logic [3:0] target, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out == target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bit ok;
        int dones;

        repeat (2) @(negedge clk);
        check("reset_out", out, 0);
        check("reset_cur_addr", cur_addr, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        reset  = 1'b0;
        enable = 1'b1;

        for (int i = 0; i < 4; i++) begin
            addr = 2'(i);
            @(negedge clk);
            check("direct_out", out, exp_direct[i]);
            check("direct_cur_addr", cur_addr, i);
        end
        enable = 1'b0;
        @(negedge clk);
        check("disabled_out", out, 0);
        check("disabled_cur_held", cur_addr, 3);

        enable = 1'b1; mode = 1'b0; start = 1'b1; addr = 2'd1;
        @(negedge clk);
        check("start_mode0_busy", busy, 0);
        check("start_mode0_out", out, 4'b0010);
        start = 1'b0;

`ifdef SCAN_DECODER_SCAN_EN
        // full scan
        mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("scan_out", out, exp_scan[i]);
            check("scan_busy", busy, 1);
            @(negedge clk);
        end
        check("scan_done_out", out, 0);
        check("scan_done_pulse", done, 1);
        @(negedge clk);
        check("scan_after_busy", busy, 0);
        check("scan_after_done", done, 0);

        // pause during the first 0100 slot
        mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = 1'b0;
        wait_out(4'b0100, ok);
        check("pause_reach_0100", ok, 1);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("pause_out", out, 0);
            check("pause_busy", busy, 1);
        end
        enable = 1'b1;
        @(negedge clk); check("resume_out0", out, 4'b0100);
        @(negedge clk); check("resume_out1", out, 4'b1000);
        @(negedge clk); check("resume_out2", out, 4'b1000);
        @(negedge clk); check("resume_done", done, 1);
        @(negedge clk);

        // start held through a scan
        dones = 0;
        mode = 1'b1; start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            mode = 1'($urandom); addr = 2'($urandom);
            if (done) dones++;
            @(negedge clk);
        end
        start = 1'b0; mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("start_in_scan_dones", dones, 1);

        // reset mid-scan
        mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = 1'b0;
        wait_out(4'b0010, ok);
        check("midreset_reach_0010", ok, 1);
        #2 reset = 1'b1;
        #1;
        check("midreset_out", out, 0);
        check("midreset_busy", busy, 0);
        check("midreset_cur_addr", cur_addr, 0);
        @(negedge clk);
        check("midreset_no_done", done, 0);
        reset = 1'b0; mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = 1'b0;
        check("restart_out", out, 4'b0001);
        check("restart_busy", busy, 1);
        repeat (10) @(negedge clk);
`else
        mode = 1'b1; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = 2'(3 - i);
            @(negedge clk);
            check("noscan_busy", busy, 0);
            check("noscan_done", done, 0);
            check("noscan_out", out, exp_direct[3 - i]);
        end
        start = 1'b0; mode = 1'b0;
`endif

        for (int k = 0; k < 400; k++) begin
            enable = ($urandom_range(9) != 0);
            mode   = 1'($urandom);
            start  = ($urandom_range(3) == 0);
            addr   = 2'($urandom);
            reset  = ($urandom_range(99) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
